// File: rtl/pb1qsys_pio_pkg.sv
// Register map shared by the PB1 Qsys parallel I/O ports (LED output and button input).
package pb1qsys_pio_pkg;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_SET   = 2'd1;
  localparam logic [1:0] ADDR_CLEAR = 2'd2;
  localparam logic [1:0] ADDR_PULSE = 2'd3;

  localparam int unsigned BUSY_BIT = 31;

endpackage

// File: rtl/pb1qsys_pulse_timer.sv
// Shared down-counter timing the self-clearing pulses of the LED output port.
module pb1qsys_pulse_timer #(
  parameter int unsigned PULSE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic active,
  output logic expire
);

  localparam int unsigned CW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(PULSE_CYCLES - 1);

  logic [CW-1:0] count;

  // A load always wins so a retrigger restarts the full period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (active && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign expire = active && (count == '0);

endmodule

// File: rtl/pb1qsys_leds_out.sv
// Avalon-MM LED/discrete output port with DATA, SET, CLEAR and timed PULSE registers.
module pb1qsys_leds_out
  import pb1qsys_pio_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int unsigned      PULSE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] wd;
  logic [31:0]      rd_d;
  logic             wr_en_c;
  logic             load_c;
  logic             expire_c;
  logic             unused_wd;

  assign wr_en_c   = chipselect && !write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata[31:WIDTH];

  pb1qsys_pulse_timer #(
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (load_c),
    .active (mask_q != '0),
    .expire (expire_c)
  );

  // Expiry is applied first; a write in the same cycle then overrides the bits it touches.
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    load_c = 1'b0;
    if (expire_c) begin
      data_d = data_q & ~mask_q;
      mask_d = '0;
    end
    if (wr_en_c) begin
      case (address)
        ADDR_DATA: begin
          data_d = wd;
          mask_d = '0;
        end
        ADDR_SET: begin
          data_d = data_d | wd;
          mask_d = mask_d & ~wd;
        end
        ADDR_CLEAR: begin
          data_d = data_d & ~wd;
          mask_d = mask_d & ~wd;
        end
        ADDR_PULSE: begin
          if (wd != '0) begin
            data_d = data_d | wd;
            mask_d = mask_d | wd;
            load_c = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA: rd_d[WIDTH-1:0] = data_q;
      ADDR_PULSE: begin
        rd_d[WIDTH-1:0] = mask_q;
        rd_d[BUSY_BIT]  = (mask_q != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      readdata <= '0;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      readdata <= rd_d;
    end
  end

  assign out_port = data_q;

endmodule
